aes_key_sched_iter: RTL and testbench
=====================================

# aes_key_sched_iter

Iterative, parametrised AES key schedule. It generates one 32-bit expanded-key word per cycle for AES-128, AES-192 or AES-256. It assembles the words into 128-bit round keys and streams them out over a valid/ready interface. It replaces the fully unrolled AES-128-only expansion in area-constrained encrypt and decrypt datapaths, which consume one round key per round.

## Interface

Parameters:
- KEY_BITS, 128: cipher key length. Legal values are 128, 192 and 256; any other value is an elaboration error.
- NK (derived), KEY_BITS/32: number of key words.
- NR (derived), NK+6: number of rounds.

Ports:
- clk  in  1  single clock; all state is on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin an expansion; accepted only in IDLE
- key_in  in  KEY_BITS  cipher key; key_in[KEY_BITS-1 -: 32] is w0; sampled only in the accept cycle
- busy  out  1  expansion in progress
- rk_valid  out  1  rk_data/rk_index valid
- rk_ready  in  1  consumer accepts the round key
- rk_data  out  128  round key r; [127:96] is w[4r], [31:0] is w[4r+3]
- rk_index  out  4  round number r, from 0 to NR
- done  out  1  one-cycle pulse after the final round key is accepted
- rd_en, rd_idx[3:0], rd_key[127:0]  in/in/out  present only with AES_KEY_SCHED_STORE_EN

## Operation

- State machine: IDLE, GEN, OUT.
- IDLE:
  - start=1 latches key_in into an NK-word window, clears the word counter i and the assembly buffer, sets rcon to 8'h01, and moves to GEN.
  - start is ignored in every other state.
- GEN: produces word i each cycle.
  - i < NK: the word is key word i.
  - i >= NK: word = w[i-NK] ^ t, where t is:
    - t = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0} when i%NK==0. After use, rcon <= xtime(rcon), where xtime is {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 0).
    - t = SubWord(w[i-1]) when NK==8 and i%NK==4.
    - t = w[i-1] otherwise.
  - The word is shifted into the window (oldest word dropped) and into the 4-word assembly buffer; i increments.
  - When i%4==3, the buffer is complete: register rk_data and rk_index=i/4, then go to OUT.
- OUT: rk_valid=1.
  - On a handshake (rk_valid && rk_ready): if rk_index==NR, go to IDLE and pulse done the next cycle; otherwise go back to GEN.
  - rk_data and rk_index are stable while rk_valid is high and rk_ready is low.
- RotWord: {w[23:0],w[31:24]}. SubWord: the S-box applied to each byte.
- Word count is 4*(NR+1): 44, 52 or 60.
- rst at any time returns to IDLE and discards the partial expansion; no done pulse is produced.

## Timing

- Reset values: busy=0, rk_valid=0, rk_data=0, rk_index=0, done=0, rd_key=0. State is IDLE, rcon is 8'h01.
- Start accepted at cycle T:
  - busy is high from T+1 through the final handshake cycle.
  - GEN runs from T+1 to T+4; first rk_valid at T+5.
- With rk_ready held high: one round key every 5 cycles. Final handshake at T+5*(NR+1) (T+55 for AES-128); done pulses at T+5*(NR+1)+1.
- Each cycle rk_ready is low in OUT adds one cycle of stall. No words are generated during a stall.
- start asserted in the same cycle as done (IDLE) is accepted.

## Configuration

- AES_KEY_SCHED_STORE_EN defined:
  - Each accepted round key is also written to an internal 15x128 register array at address rk_index.
  - rd_en=1 returns entry rd_idx on rd_key at the next edge (1-cycle latency). Otherwise rd_key holds its value.
  - Entries persist until overwritten by a later expansion. Reset clears rd_key but not the array.
  - rd_idx > NR returns 0.
- Not defined: the array and the rd_* ports are absent; the block is stream-only.

## Structure

- Package aes_pkg holds:
  - the state enum;
  - the xtime/rcon function;
  - the constants KEY_BITS-to-NK and NR;
  - the RK_IDX_W=4 width.
- One sub-module, aes_sub_word: 32-bit SubWord built from four instances of the existing S-box. A single instance is shared for both the RotWord and the NK==8 cases.

## Test plan

- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - r0 equals the key; r1=a0fafe1788542cb123a339392a6c7605; r10=d014f9a8c9ee2589e13f0cc8b6630ca6;
  - first rk_valid at T+5; done at T+56.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: r12=e98ba06f448c773c8ecc720401002202; rk_index runs 0..12.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - r1=1f352c073b6108d72d9810a30914dff4;
  - r2[127:96]=9ba35411;
  - r14=fe4890d1e6188d0b046df344706c631e.
- Backpressure on AES-128: rk_ready low for 7 cycles at r3. rk_data and rk_index stay constant; all keys are still correct; done is delayed by exactly 7 cycles.
- start pulsed mid-expansion is ignored. rst asserted at r5, then a restart with a new key: the output matches that key's schedule from r0, and no done pulse occurs before the new expansion completes.
- With AES_KEY_SCHED_STORE_EN, after the AES-128 run: rd_idx=10 returns d014f9a8c9ee2589e13f0cc8b6630ca6 one cycle later; rd_idx=12 returns 0.

Source files
------------

// File: rtl/aes_key_sched_iter_pkg.sv
// aes_pkg: shared FSM type, key-size constants and GF(2^8) helpers for the AES key schedule
package aes_pkg;

    localparam int RK_IDX_W = 4;

    typedef enum logic [1:0] {IDLE, GEN, OUT} state_t;

    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (a^254, zero maps to zero) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq, inv, c, s;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        c = 8'h63;
        for (int k = 0; k < 8; k++)
            s[k] = inv[k] ^ inv[(k + 4) % 8] ^ inv[(k + 5) % 8] ^ inv[(k + 6) % 8] ^ inv[(k + 7) % 8] ^ c[k];
        return s;
    endfunction

endpackage

// File: rtl/aes_key_sched_iter_sub_word.sv
// aes_sub_word: 32-bit SubWord built from four byte-wide S-box instances
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);
    assign s = sbox(a);
endmodule

module aes_sub_word (
    input  logic [31:0] w,
    output logic [31:0] s
);
    for (genvar b = 0; b < 4; b++) begin : g_byte
        aes_sbox u_sbox (.a(w[8*b +: 8]), .s(s[8*b +: 8]));
    end
endmodule

// File: rtl/aes_key_sched_iter.sv
// aes_key_sched_iter: iterative AES-128/192/256 key expansion, one word per cycle, round keys
// streamed over valid/ready. Define AES_KEY_SCHED_STORE_EN to also keep every round key in a
// 15-entry array readable through the rd_* port.
module aes_key_sched_iter
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [127:0]        rk_data,
    output logic [RK_IDX_W-1:0] rk_index,
    output logic                done
`ifdef AES_KEY_SCHED_STORE_EN
    ,
    input  logic                rd_en,
    input  logic [RK_IDX_W-1:0] rd_idx,
    output logic [127:0]        rd_key
`endif
);
    localparam int NK = nk_of(KEY_BITS);
    localparam int NR = nr_of(KEY_BITS);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_sched_iter: KEY_BITS must be 128, 192 or 256");
    end

    state_t      state;
    logic [31:0] win [NK];
    logic [31:0] asm_buf [3];
    logic [5:0]  cnt;
    logic [2:0]  phase;
    logic [7:0]  rcon;
    logic [31:0] prev, sw_in, sw_out, t, word;
    logic        hs;

    assign prev = win[NK-1];
    assign hs   = rk_valid && rk_ready;

    // Next word: key words pass through first, then w[i-NK] ^ t with the shared SubWord.
    always_comb begin
        sw_in = (phase == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
        t     = (phase == 3'd0) ? sw_out ^ {rcon, 24'h0} : (NK == 8 && phase == 3'd4) ? sw_out : prev;
        word  = (cnt < 6'(NK)) ? win[0] : win[0] ^ t;
    end

    aes_sub_word u_sub_word (.w(sw_in), .s(sw_out));

    // Control FSM with the sliding key window (win[0] oldest), assembly buffer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_index <= '0;
            done     <= 1'b0;
            cnt      <= '0;
            phase    <= '0;
            rcon     <= 8'h01;
            for (int k = 0; k < NK; k++) win[k] <= '0;
            for (int k = 0; k < 3; k++) asm_buf[k] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    for (int k = 0; k < NK; k++) win[k] <= key_in[KEY_BITS-1-32*k -: 32];
                    for (int k = 0; k < 3; k++) asm_buf[k] <= '0;
                    cnt   <= '0;
                    phase <= '0;
                    rcon  <= 8'h01;
                    busy  <= 1'b1;
                    state <= GEN;
                end
                GEN: begin
                    for (int k = 0; k < NK - 1; k++) win[k] <= win[k+1];
                    win[NK-1]  <= word;
                    asm_buf[0] <= asm_buf[1];
                    asm_buf[1] <= asm_buf[2];
                    asm_buf[2] <= word;
                    cnt        <= cnt + 6'd1;
                    phase      <= (phase == 3'(NK - 1)) ? 3'd0 : phase + 3'd1;
                    if (cnt >= 6'(NK) && phase == 3'd0) rcon <= xtime(rcon);
                    if (cnt[1:0] == 2'd3) begin
                        rk_data  <= {asm_buf[0], asm_buf[1], asm_buf[2], word};
                        rk_index <= cnt[5:2];
                        rk_valid <= 1'b1;
                        state    <= OUT;
                    end
                end
                OUT: if (hs) begin
                    rk_valid <= 1'b0;
                    if (rk_index == RK_IDX_W'(NR)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= GEN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AES_KEY_SCHED_STORE_EN
    logic [127:0] store [15];

    // Record each accepted round key; contents survive reset and later reads.
    always_ff @(posedge clk) begin
        if (hs) store[rk_index] <= rk_data;
    end

    // One-cycle read port; indices beyond the final round read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_key <= '0;
        else if (rd_en) rd_key <= (rd_idx > RK_IDX_W'(NR)) ? '0 : store[rd_idx];
    end
`endif

endmodule

// File: tb/tb_aes_key_sched_iter.sv
// tb_aes_key_sched_iter: scoreboard bench for AES-128/192/256 instances against a software key expansion
`timescale 1ns/1ps
module tb_aes_key_sched_iter;

    typedef struct {
        int           dut;
        logic [3:0]   idx;
        logic [127:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   start, busy, rk_valid, rk_ready, done;
    logic [255:0] key [3];
    logic [127:0] rk_data [3];
    logic [3:0]   rk_index [3];
`ifdef AES_KEY_SCHED_STORE_EN
    logic [2:0]   rd_en;
    logic [3:0]   rd_idx [3];
    logic [127:0] rd_key [3];
`endif
    int           errs = 0;
    int           checks = 0;
    logic [7:0]   sb_tab [256];
    logic [127:0] got [3][15];
    exp_t         sb [$];
    logic [2:0]   stall_prev;
    logic [127:0] pdata [3];
    logic [3:0]   pidx [3];
    logic [31:0]  word_hi;

    localparam logic [255:0] K128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] K192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int KB = 128 + 64 * g;
        aes_key_sched_iter #(.KEY_BITS(KB)) u_dut (
            .clk(clk), .rst(rst), .start(start[g]), .key_in(key[g][KB-1:0]), .busy(busy[g]),
            .rk_valid(rk_valid[g]), .rk_ready(rk_ready[g]), .rk_data(rk_data[g]),
            .rk_index(rk_index[g]), .done(done[g])
`ifdef AES_KEY_SCHED_STORE_EN
            , .rd_en(rd_en[g]), .rd_idx(rd_idx[g]), .rd_key(rd_key[g])
`endif
        );
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // S-box table from the generator-3 walk: p steps by *3, q by /3 so q = p^-1, then affine.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        repeat (255) begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb_tab[p] = x ^ 8'h63;
        end
        sb_tab[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_w(input logic [31:0] w);
        return {sb_tab[w[31:24]], sb_tab[w[23:16]], sb_tab[w[15:8]], sb_tab[w[7:0]]};
    endfunction

    // Whole-array key expansion; key is right-aligned in k.
    task automatic expand(input logic [255:0] k, input int nk, output logic [127:0] rk [15]);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = k[32*(nk-1-i) +: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = (rc << 1) ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_w(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            chk("done_idle", 128'(done), 128'(0));
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks hold-steady during stalls.
    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < 3; g++) begin
            if (rst) begin
                stall_prev[g] = 1'b0;
            end else begin
                if (stall_prev[g]) begin
                    chk("stall_valid", 128'(rk_valid[g]), 128'(1));
                    chk("stall_data", rk_data[g], pdata[g]);
                    chk("stall_index", 128'(rk_index[g]), 128'(pidx[g]));
                end
                stall_prev[g] = rk_valid[g] && !rk_ready[g];
                pdata[g] = rk_data[g];
                pidx[g]  = rk_index[g];
                if (rk_valid[g] && rk_ready[g]) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errs++;
                        $display("FAIL sb_empty: dut %0d emitted round %0d with nothing expected", g, rk_index[g]);
                    end else begin
                        e = sb.pop_front();
                        chk("rk_dut", 128'(g), 128'(e.dut));
                        chk("rk_index", 128'(rk_index[g]), 128'(e.idx));
                        chk("rk_data", rk_data[g], e.data);
                        got[g][rk_index[g]] = rk_data[g];
                    end
                end
            end
        end
    end

    // One full expansion on instance g; entered and left at #1 after a rising edge.
    task automatic run(input int g, input logic [255:0] k, input int stall, input int abort_at);
        int           nr, c, fv, dn, left;
        bit           stalled;
        logic [127:0] rk [15];
        nr = (128 + 64 * g) / 32 + 6;
        expand(k, nr - 6, rk);
        for (int r = 0; r < 15; r++) got[g][r] = '0;
        for (int r = 0; r <= nr; r++) sb.push_back('{g, 4'(r), rk[r]});
        key[g]   = k;
        start[g] = 1'b1;
        @(posedge clk); #1;
        start[g] = 1'b0;
        key[g]   = rand_key();
        fv = -1;
        dn = -1;
        left = 0;
        stalled = 1'b0;
        for (c = 1; c < 200; c++) begin
            if (c == 1) chk("busy_start", 128'(busy[g]), 128'(1));
            if (fv < 0 && rk_valid[g]) fv = c;
            if (done[g]) begin
                dn = c;
                break;
            end
            if (abort_at >= 0 && rk_valid[g] && rk_index[g] == 4'(abort_at)) begin
                rk_ready[g] = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                chk("abort_busy", 128'(busy[g]), 128'(0));
                chk("abort_valid", 128'(rk_valid[g]), 128'(0));
                chk("abort_done", 128'(done[g]), 128'(0));
                rst = 1'b0;
                rk_ready[g] = 1'b1;
                sb.delete();
                return;
            end
            if (left > 0) begin
                rk_ready[g] = 1'b0;
                left--;
            end else if (stall > 0 && !stalled && rk_valid[g] && rk_index[g] == 4'd3) begin
                rk_ready[g] = 1'b0;
                left = stall - 1;
                stalled = 1'b1;
            end else begin
                rk_ready[g] = 1'b1;
            end
            start[g] = (c == 20);
            @(posedge clk); #1;
        end
        start[g] = 1'b0;
        rk_ready[g] = 1'b1;
        if (abort_at >= 0) begin
            checks++;
            errs++;
            $display("FAIL abort_missed: round %0d never presented, done at cycle %0d", abort_at, dn);
        end
        chk("first_valid", 128'(fv), 128'(5));
        chk("done_cycle", 128'(dn), 128'(5 * (nr + 1) + 1 + stall));
        chk("busy_done", 128'(busy[g]), 128'(0));
        chk("sb_drained", 128'(sb.size()), 128'(0));
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        build_sbox();
        rst = 1'b1;
        start = '0;
        rk_ready = '1;
        stall_prev = '0;
        for (int g = 0; g < 3; g++) key[g] = '0;
`ifdef AES_KEY_SCHED_STORE_EN
        rd_en = '0;
        for (int g = 0; g < 3; g++) rd_idx[g] = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("rst_data", rk_data[g], 128'(0));
            chk("rst_ctrl", 128'({busy[g], rk_valid[g], done[g], rk_index[g]}), 128'(0));
`ifdef AES_KEY_SCHED_STORE_EN
            chk("rst_rd_key", rd_key[g], 128'(0));
`endif
        end
        rst = 1'b0;
        idle(2);

        run(0, K128, 0, -1);
        chk("aes128_r0", got[0][0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("aes128_r1", got[0][1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("aes128_r10", got[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`ifdef AES_KEY_SCHED_STORE_EN
        rd_en[0] = 1'b1;
        rd_idx[0] = 4'd10;
        @(posedge clk); #1;
        chk("rd_key_10", rd_key[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd_idx[0] = 4'd12;
        @(posedge clk); #1;
        chk("rd_key_12", rd_key[0], 128'(0));
        rd_idx[0] = 4'd0;
        @(posedge clk); #1;
        chk("rd_key_0", rd_key[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        rd_en[0] = 1'b0;
        rd_idx[0] = 4'd5;
        @(posedge clk); #1;
        chk("rd_key_hold", rd_key[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
`endif
        idle(2);

        run(0, K128, 7, -1);
        chk("stall_r10", got[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        run(0, rand_key(), 0, -1);
        idle(1);

        run(1, K192, 0, -1);
        chk("aes192_r12", got[1][12], 128'he98ba06f448c773c8ecc720401002202);
        idle(1);

        run(2, K256, 0, -1);
        chk("aes256_r1", got[2][1], 128'h1f352c073b6108d72d9810a30914dff4);
        word_hi = got[2][2][127:96];
        chk("aes256_r2_w8", 128'(word_hi), 128'h9ba35411);
        chk("aes256_r14", got[2][14], 128'hfe4890d1e6188d0b046df344706c631e);
        idle(1);

        run(0, rand_key(), 0, 5);
        run(0, rand_key(), 0, -1);

        for (int n = 0; n < 2; n++) begin
            for (int g = 0; g < 3; g++) begin
                idle(1);
                run(g, rand_key(), int'($urandom_range(0, 4)), -1);
            end
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
